// File: rtl/gpca_if.sv
// Operand/result bundle for the gpca arithmetic block; vectors use [1:N] with bit 1 as MSB.
interface gpca_if;
  logic        X;
  logic [1:5]  P;
  logic [1:7]  B;
  logic [1:7]  C;
  logic [1:10] A;
  logic [1:5]  F;
  logic [1:11] S;

  modport master (output X, P, B, C, A, input F, S);
  modport slave  (input X, P, B, C, A, output F, S);
endinterface

// File: rtl/gpca.sv
// Unsigned MAC / square-acc / divide / sqrt unit built from 5 shift-add or restoring rows.
// Latency 2 cycles (inputs registered, then result registered), one result per cycle, no stalls.
module gpca (
  input  logic  clk,
  input  logic  rst_n,
  gpca_if.slave bus
);

  localparam logic [1:7] SELF_CODE = 7'b0100000;

  logic        x_q;
  logic [1:5]  p_q;
  logic [1:7]  b_q;
  logic [1:7]  c_q;
  logic [1:10] a_q;
  logic [1:5]  f_q, f_d;
  logic [1:11] s_q, s_d;

  logic        self_mode;
  logic [4:0]  p_v;
  logic [6:0]  mcand;
  logic [10:0] mac_acc;
  logic [10:0] dvs;
  logic [10:0] rem;
  logic [4:0]  quo;
  logic        div_ovf;
  logic [4:0]  root;
  logic [4:0]  trial;
  logic [9:0]  trial_sq;
  logic [9:0]  root_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 1'b0;
      p_q <= '0;
      b_q <= '0;
      c_q <= '0;
      a_q <= '0;
      f_q <= '0;
      s_q <= '0;
    end else begin
      x_q <= bus.X;
      p_q <= bus.P;
      b_q <= bus.B;
      c_q <= bus.C;
      a_q <= bus.A;
      f_q <= f_d;
      s_q <= s_d;
    end
  end

  assign self_mode = (c_q == SELF_CODE);
  assign p_v       = p_q;

  // Multiply and square share one array; the 11-bit accumulator gives the mod-2048 wrap.
  always_comb begin
    mcand   = self_mode ? {2'b00, p_v} : b_q;
    mac_acc = {1'b0, a_q};
    for (int i = 0; i < 5; i++) begin
      if (p_v[i]) mac_acc = mac_acc + ({4'b0000, mcand} << i);
    end
  end

  // A quotient above 31 is exactly A >= 32*B, caught before the five restoring rows.
  always_comb begin
    dvs     = {4'b0000, b_q};
    div_ovf = (b_q == 7'd0) || ({2'b00, a_q} >= {b_q, 5'b00000});
    rem     = {1'b0, a_q};
    quo     = '0;
    for (int i = 4; i >= 0; i--) begin
      if (rem >= (dvs << i)) begin
        rem    = rem - (dvs << i);
        quo[i] = 1'b1;
      end
    end
  end

  always_comb begin
    root     = '0;
    trial    = '0;
    trial_sq = '0;
    for (int i = 4; i >= 0; i--) begin
      trial    = root | (5'd1 << i);
      trial_sq = {5'b00000, trial} * {5'b00000, trial};
      if (trial_sq <= a_q) root = trial;
    end
    root_rem = a_q - ({5'b00000, root} * {5'b00000, root});
  end

  always_comb begin
    f_d = '0;
    s_d = '0;
    case ({x_q, self_mode})
      2'b00, 2'b01: s_d = mac_acc;
      2'b10: begin
        if (div_ovf) begin
          f_d = '1;
          s_d = '1;
        end else begin
          f_d = quo;
          s_d = rem;
        end
      end
      default: begin
        f_d = root;
        s_d = {1'b0, root_rem};
      end
    endcase
  end

  assign bus.F = f_q;
  assign bus.S = s_q;

endmodule

// File: tb/tb_gpca.sv
// Directed-vector bench for gpca: back-to-back mixed-mode vectors plus reset checks.
module tb_gpca;

  logic clk;
  logic rst_n;

  gpca_if bus ();

  gpca dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic x;
    int   p;
    int   b;
    int   c;
    int   a;
    int   f;
    int   s;
  } vec_t;

  vec_t vt[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.X = v.x;
    bus.P = 5'(v.p);
    bus.B = 7'(v.b);
    bus.C = 7'(v.c);
    bus.A = 10'(v.a);
  endtask

  initial begin
    //            x     p   b    c     a     f   s
    vt.push_back('{1'b0,  5,   7,   0,    0,  0,   35});
    vt.push_back('{1'b0, 31, 127,   0,   10,  0, 1899});
    vt.push_back('{1'b0,  5,  31, 32,     0,  0,   25});
    vt.push_back('{1'b0, 31,  99, 32,  1023,  0, 1984});
    vt.push_back('{1'b1, 17,  55, 32,    25,  5,    0});
    vt.push_back('{1'b1, 31, 127, 32,  1023, 31,   62});
    vt.push_back('{1'b1,  9,   3, 32,     0,  0,    0});
    vt.push_back('{1'b1, 31,   5,  5,    35,  7,    0});
    vt.push_back('{1'b1,  0,   5,  5,    37,  7,    2});
    vt.push_back('{1'b1, 12,   0,  5,    37, 31, 2047});
    vt.push_back('{1'b1,  3,   2,  5,  1000, 31, 2047});
    vt.push_back('{1'b1,  0,  32,  0,  1023, 31,   31});
    vt.push_back('{1'b1,  0,   1,  0,    31, 31,    0});
    vt.push_back('{1'b1,  0,   1,  0,    32, 31, 2047});
    vt.push_back('{1'b0,  3,   4, 33,     1,  0,   13});
    vt.push_back('{1'b0,  0,   0,  0,  1023,  0, 1023});
    vt.push_back('{1'b1,  7,   9, 32,    24,  4,    8});
    vt.push_back('{1'b0,  7,   9,  0,   100,  0,  163});
  end

  initial begin
    vec_t v0;
    rst_n = 1'b0;
    bus.X = 1'b1;
    bus.P = 5'd21;
    bus.B = 7'd100;
    bus.C = 7'd3;
    bus.A = 10'd777;
    #1;
    chk("reset_F", int'(bus.F), 0);
    chk("reset_S", int'(bus.S), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held_F", int'(bus.F), 0);
    chk("reset_held_S", int'(bus.S), 0);

    // Apply vector k at negedge k; its result is visible at negedge k+2.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < vt.size() + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("v%0d_F", k - 2), int'(bus.F), vt[k - 2].f);
        chk($sformatf("v%0d_S", k - 2), int'(bus.S), vt[k - 2].s);
      end
      if (k < vt.size()) drive(vt[k]);
    end

    // Mid-operation reset with arbitrary inputs: outputs clear at once and stay clear.
    bus.X = 1'($urandom);
    bus.P = 5'($urandom);
    bus.B = 7'($urandom);
    bus.C = 7'($urandom);
    bus.A = 10'($urandom);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_F", int'(bus.F), 0);
    chk("mid_reset_S", int'(bus.S), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_held_F", int'(bus.F), 0);
    chk("mid_held_S", int'(bus.S), 0);

    v0 = vt[0];
    @(negedge clk);
    drive(v0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_1edge_S", int'(bus.S), 0);
    @(negedge clk);
    chk("post_rst_2edge_F", int'(bus.F), v0.f);
    chk("post_rst_2edge_S", int'(bus.S), v0.s);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
